mem_line_ctrl: RTL and testbench

// Memory-side controller directly downstream of the cache arbiter. Takes one 512-bit line

---
 rtl/mem_bus_pkg.sv | 34 +++
 rtl/mem_line_ctrl_if.sv | 43 ++++
 rtl/line_beat_buf.sv | 59 +++++
 rtl/mem_line_ctrl.sv | 141 ++++++++++++++
 tb/tb_mem_line_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the line controller, the cache arbiter and the bus model:
// bus geometry, response/request tag values and the controller state encoding.
package mem_bus_pkg;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned LINE_W = 512;
    localparam int unsigned BUS_W  = 64;
    localparam int unsigned BEATS  = LINE_W / BUS_W;
    localparam int unsigned CNT_W  = $clog2(BEATS);
    localparam int unsigned TAG_W  = 13;
    localparam int unsigned OFFS_W = $clog2(LINE_W / 8);

    localparam logic [TAG_W-1:0] TAG_READ  = TAG_W'(1);
    localparam logic [TAG_W-1:0] TAG_WRITE = TAG_W'(2);
    localparam logic [TAG_W-1:0] TAG_INVAL = TAG_W'(4);

    localparam logic [CNT_W-1:0]  LAST_BEAT      = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] LINE_ADDR_MASK = ~ADDR_W'((1 << OFFS_W) - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdResp,
        StWrAddr,
        StWrData,
        StDone
    } mem_ctrl_state_t;

    // Align a byte address down to the start of its cache line.
    function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
        return a & LINE_ADDR_MASK;
    endfunction

endpackage

// File: rtl/mem_line_ctrl_if.sv
// Signal bundle between the line controller, the cache arbiter and the tagged system bus.
//   arbiter side : mem_req, mem_address, mem_data_out, mem_wr_en (to controller)
//                  data_from_mem, mem_data_valid, invalidate_cache(_addr) (from controller)
//   bus side     : bus_reqcyc, bus_req, bus_reqtag, bus_respack (from controller)
//                  bus_reqack, bus_respcyc, bus_resp, bus_resptag (to controller)
// master : the controller view (it masters bus transactions)
// slave  : the environment view (arbiter plus bus model)
interface mem_line_ctrl_if;
    import mem_bus_pkg::*;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_data_out;
    logic              mem_wr_en;
    logic [LINE_W-1:0] data_from_mem;
    logic              mem_data_valid;
    logic              invalidate_cache;
    logic [ADDR_W-1:0] invalidate_cache_addr;

    logic              bus_reqcyc;
    logic [BUS_W-1:0]  bus_req;
    logic [TAG_W-1:0]  bus_reqtag;
    logic              bus_reqack;
    logic              bus_respcyc;
    logic [BUS_W-1:0]  bus_resp;
    logic [TAG_W-1:0]  bus_resptag;
    logic              bus_respack;

    modport master (
        input  mem_req, mem_address, mem_data_out, mem_wr_en,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag,
        output data_from_mem, mem_data_valid, invalidate_cache, invalidate_cache_addr,
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack
    );

    modport slave (
        output mem_req, mem_address, mem_data_out, mem_wr_en,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag,
        input  data_from_mem, mem_data_valid, invalidate_cache, invalidate_cache_addr,
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack
    );

endinterface

// File: rtl/line_beat_buf.sv
// Line buffer with beat access.
//   clk, rst            : clock, asynchronous active-low reset
//   load, load_line     : replace the whole line (takes priority over beat writes)
//   beat_we, beat_wdata : write one bus beat at the current counter index
//   cnt_inc, cnt_clr    : advance (wrapping) or clear the beat counter
//   line_next           : line as it will be after this cycle's beat write
//   beat_rdata          : beat at the current counter index
//   cnt                 : current beat index
module line_beat_buf
    import mem_bus_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LINE_W-1:0] load_line,
    input  logic              beat_we,
    input  logic [BUS_W-1:0]  beat_wdata,
    input  logic              cnt_inc,
    input  logic              cnt_clr,
    output logic [LINE_W-1:0] line_next,
    output logic [BUS_W-1:0]  beat_rdata,
    output logic [CNT_W-1:0]  cnt
);

    logic [LINE_W-1:0] line_q, line_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        line_next = line_q;
        if (beat_we) begin
            line_next[cnt_q*BUS_W +: BUS_W] = beat_wdata;
        end
        line_d = load ? load_line : line_next;
    end

    // Counter width equals log2(BEATS), so the increment wraps naturally after the last beat.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_q <= '0;
            cnt_q  <= '0;
        end else begin
            line_q <= line_d;
            cnt_q  <= cnt_d;
        end
    end

    assign beat_rdata = line_q[cnt_q*BUS_W +: BUS_W];
    assign cnt        = cnt_q;

endmodule

// File: rtl/mem_line_ctrl.sv
// Memory-side line controller: runs one 512-bit line read or write as eight 64-bit beats on
// the tagged system bus, returns read lines to the arbiter with a one-cycle valid pulse, and
// forwards bus invalidation snoops.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : arbiter request/response and system bus signals (mem_line_ctrl_if.master)
module mem_line_ctrl
    import mem_bus_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    mem_line_ctrl_if.master bus
);

    mem_ctrl_state_t   state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] data_q;
    logic              inv_q;
    logic [ADDR_W-1:0] inv_addr_q;

    logic              buf_load, buf_we, cnt_inc, cnt_clr;
    logic [LINE_W-1:0] line_next;
    logic [BUS_W-1:0]  beat_rdata;
    logic [CNT_W-1:0]  cnt;

    logic              read_resp, inval_resp, accept, rd_last;
    logic              reqcyc;
    logic [BUS_W-1:0]  req;
    logic [TAG_W-1:0]  reqtag;

    assign read_resp  = bus.bus_respcyc && (bus.bus_resptag == TAG_READ);
    assign inval_resp = bus.bus_respcyc && (bus.bus_resptag == TAG_INVAL);
    assign accept     = (state_q == StIdle) && bus.mem_req;
    assign rd_last    = (state_q == StRdResp) && read_resp && (cnt == LAST_BEAT);

    line_beat_buf u_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .load_line  (bus.mem_data_out),
        .beat_we    (buf_we),
        .beat_wdata (bus.bus_resp),
        .cnt_inc    (cnt_inc),
        .cnt_clr    (cnt_clr),
        .line_next  (line_next),
        .beat_rdata (beat_rdata),
        .cnt        (cnt)
    );

    always_comb begin
        state_d  = state_q;
        buf_load = 1'b0;
        buf_we   = 1'b0;
        cnt_inc  = 1'b0;
        cnt_clr  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.mem_req) begin
                    buf_load = 1'b1;
                    cnt_clr  = 1'b1;
                    state_d  = bus.mem_wr_en ? StWrAddr : StRdReq;
                end
            end
            StRdReq: begin
                if (bus.bus_reqack) state_d = StRdResp;
            end
            StRdResp: begin
                if (read_resp) begin
                    buf_we  = 1'b1;
                    cnt_inc = 1'b1;
                    if (cnt == LAST_BEAT) state_d = StDone;
                end
            end
            StWrAddr: begin
                if (bus.bus_reqack) begin
                    cnt_clr = 1'b1;
                    state_d = StWrData;
                end
            end
            StWrData: begin
                if (bus.bus_reqack) begin
                    cnt_inc = 1'b1;
                    if (cnt == LAST_BEAT) state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        reqcyc = 1'b0;
        req    = '0;
        reqtag = '0;
        case (state_q)
            StRdReq: begin
                reqcyc = 1'b1;
                req    = addr_q;
                reqtag = TAG_READ;
            end
            StWrAddr: begin
                reqcyc = 1'b1;
                req    = addr_q;
                reqtag = TAG_WRITE;
            end
            StWrData: begin
                reqcyc = 1'b1;
                req    = beat_rdata;
                reqtag = TAG_WRITE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            data_q     <= '0;
            inv_q      <= 1'b0;
            inv_addr_q <= '0;
        end else begin
            state_q <= state_d;
            inv_q   <= inval_resp;
            if (accept)     addr_q     <= line_addr(bus.mem_address);
            // Capture including the final beat so the line is visible alongside the valid pulse.
            if (rd_last)    data_q     <= line_next;
            if (inval_resp) inv_addr_q <= line_addr(bus.bus_resp);
        end
    end

    assign bus.bus_reqcyc            = reqcyc;
    assign bus.bus_req               = req;
    assign bus.bus_reqtag            = reqtag;
    // Read beats are acked in every state (stray ones are dropped); unknown tags are left unacked.
    assign bus.bus_respack           = rst && (read_resp || inval_resp);
    assign bus.mem_data_valid        = (state_q == StDone);
    assign bus.data_from_mem         = data_q;
    assign bus.invalidate_cache      = inv_q;
    assign bus.invalidate_cache_addr = inv_addr_q;

endmodule

// File: tb/tb_mem_line_ctrl.sv
module tb_mem_line_ctrl;
    import mem_bus_pkg::*;

    typedef logic [LINE_W-1:0] wide_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_line_ctrl_if bus_if ();

    mem_line_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int    n_checks  = 0;
    int    n_fail    = 0;
    int    cyc       = 0;
    int    valid_cnt = 0;
    wide_t model_line = '0;

    always @(negedge clk) begin
        if (bus_if.mem_data_valid === 1'b1) valid_cnt <= valid_cnt + 1;
    end

    task automatic check_eq(input string tag, input wide_t got, input wide_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        bus_if.mem_req      = 1'b0;
        bus_if.mem_address  = '0;
        bus_if.mem_data_out = '0;
        bus_if.mem_wr_en    = 1'b0;
        bus_if.bus_reqack   = 1'b0;
        bus_if.bus_respcyc  = 1'b0;
        bus_if.bus_resp     = '0;
        bus_if.bus_resptag  = '0;
    endtask

    function automatic wide_t rand_line();
        wide_t l;
        for (int k = 0; k < LINE_W / 32; k++) l[32*k +: 32] = $urandom;
        return l;
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_reqcyc"}, LINE_W'(bus_if.bus_reqcyc), '0);
        check_eq({tag, "_req"}, LINE_W'(bus_if.bus_req), '0);
        check_eq({tag, "_valid"}, LINE_W'(bus_if.mem_data_valid), '0);
        check_eq({tag, "_data"}, bus_if.data_from_mem, '0);
        check_eq({tag, "_inv"}, LINE_W'(bus_if.invalidate_cache), '0);
        check_eq({tag, "_respack"}, LINE_W'(bus_if.bus_respack), '0);
    endtask

    // Read: edge 0 takes the request, 'extra' counts every non-beat cycle on the response side.
    task automatic do_read(input logic [ADDR_W-1:0] addr, input wide_t line, input int ack_dly,
                           input int gap_max, input int snoop_after,
                           input logic [ADDR_W-1:0] snoop_addr, input int rst_after,
                           input bit poke_req);
        int start, extra, vstart, gap;
        logic [ADDR_W-1:0] exp_addr;
        exp_addr = addr & ~ADDR_W'(63);
        vstart   = valid_cnt;
        extra    = 0;
        bus_if.mem_req      = 1'b1;
        bus_if.mem_address  = addr;
        bus_if.mem_wr_en    = 1'b0;
        bus_if.mem_data_out = rand_line();
        tick();
        start = cyc;
        bus_if.mem_req     = 1'b0;
        bus_if.mem_address = {$urandom, $urandom};
        for (int i = 0; i <= ack_dly; i++) begin
            check_eq("rd_reqcyc", LINE_W'(bus_if.bus_reqcyc), LINE_W'(1));
            check_eq("rd_req_addr", LINE_W'(bus_if.bus_req), LINE_W'(exp_addr));
            check_eq("rd_reqtag", LINE_W'(bus_if.bus_reqtag), LINE_W'(TAG_READ));
            if (i == ack_dly) bus_if.bus_reqack = 1'b1;
            tick();
        end
        bus_if.bus_reqack = 1'b0;
        for (int k = 0; k < BEATS; k++) begin
            gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            if (poke_req && k == 2 && gap == 0) gap = 1;
            for (int g = 0; g < gap; g++) begin
                if (poke_req && k == 2 && g == 0) begin
                    bus_if.mem_req   = 1'b1;
                    bus_if.mem_wr_en = 1'b1;
                end
                tick();
                bus_if.mem_req   = 1'b0;
                bus_if.mem_wr_en = 1'b0;
                extra++;
            end
            bus_if.bus_respcyc = 1'b1;
            bus_if.bus_resptag = TAG_READ;
            bus_if.bus_resp    = line[BUS_W*k +: BUS_W];
            #1;
            check_eq("rd_beat_respack", LINE_W'(bus_if.bus_respack), LINE_W'(1));
            tick();
            bus_if.bus_respcyc = 1'b0;
            if (snoop_after == k - 1)
                check_eq("inv_pulse_end", LINE_W'(bus_if.invalidate_cache), '0);
            if (rst_after == k) begin
                rst = 1'b0;
                #1;
                check_all_zero("rst_mid");
                check_eq("rst_mid_reqtag", LINE_W'(bus_if.bus_reqtag), '0);
                repeat (2) tick();
                rst = 1'b1;
                tick();
                check_eq("rst_no_valid", LINE_W'(valid_cnt - vstart), '0);
                check_eq("rst_idle_reqcyc", LINE_W'(bus_if.bus_reqcyc), '0);
                model_line = '0;
                return;
            end
            if (snoop_after == k) begin
                bus_if.bus_respcyc = 1'b1;
                bus_if.bus_resptag = TAG_INVAL;
                bus_if.bus_resp    = snoop_addr;
                #1;
                check_eq("snoop_respack", LINE_W'(bus_if.bus_respack), LINE_W'(1));
                tick();
                bus_if.bus_respcyc = 1'b0;
                check_eq("snoop_inv", LINE_W'(bus_if.invalidate_cache), LINE_W'(1));
                check_eq("snoop_inv_addr", LINE_W'(bus_if.invalidate_cache_addr),
                         LINE_W'(snoop_addr & ~ADDR_W'(63)));
                extra++;
            end
        end
        model_line = line;
        check_eq("rd_valid", LINE_W'(bus_if.mem_data_valid), LINE_W'(1));
        check_eq("rd_valid_cycle", LINE_W'(cyc - start + 1), LINE_W'(10 + ack_dly + extra));
        check_eq("rd_data", bus_if.data_from_mem, model_line);
        tick();
        check_eq("rd_valid_drop", LINE_W'(bus_if.mem_data_valid), '0);
        check_eq("rd_idle_reqcyc", LINE_W'(bus_if.bus_reqcyc), '0);
        check_eq("rd_valid_count", LINE_W'(valid_cnt - vstart), LINE_W'(1));
        check_eq("rd_data_hold", bus_if.data_from_mem, model_line);
    endtask

    // Write: bus must present the line address then beats 0..7, each held until acked.
    task automatic do_write(input logic [ADDR_W-1:0] addr, input wide_t line, input int dmin,
                            input int dmax);
        int start, vstart, total, d;
        logic [BUS_W-1:0] word;
        vstart = valid_cnt;
        total  = 0;
        bus_if.mem_req      = 1'b1;
        bus_if.mem_address  = addr;
        bus_if.mem_wr_en    = 1'b1;
        bus_if.mem_data_out = line;
        tick();
        start = cyc;
        bus_if.mem_req      = 1'b0;
        bus_if.mem_wr_en    = 1'b0;
        bus_if.mem_address  = {$urandom, $urandom};
        bus_if.mem_data_out = rand_line();
        for (int w = 0; w <= BEATS; w++) begin
            word = (w == 0) ? (addr & ~ADDR_W'(63)) : line[BUS_W*(w-1) +: BUS_W];
            d = int'($urandom_range(dmax, dmin));
            total += d;
            for (int i = 0; i <= d; i++) begin
                check_eq("wr_reqcyc", LINE_W'(bus_if.bus_reqcyc), LINE_W'(1));
                check_eq("wr_req_word", LINE_W'(bus_if.bus_req), LINE_W'(word));
                check_eq("wr_reqtag", LINE_W'(bus_if.bus_reqtag), LINE_W'(TAG_WRITE));
                check_eq("wr_early_valid", LINE_W'(bus_if.mem_data_valid), '0);
                if (i == d) bus_if.bus_reqack = 1'b1;
                tick();
            end
            bus_if.bus_reqack = 1'b0;
        end
        check_eq("wr_valid", LINE_W'(bus_if.mem_data_valid), LINE_W'(1));
        check_eq("wr_valid_cycle", LINE_W'(cyc - start + 1), LINE_W'(10 + total));
        check_eq("wr_data_kept", bus_if.data_from_mem, model_line);
        tick();
        check_eq("wr_valid_drop", LINE_W'(bus_if.mem_data_valid), '0);
        check_eq("wr_idle_reqcyc", LINE_W'(bus_if.bus_reqcyc), '0);
        check_eq("wr_valid_count", LINE_W'(valid_cnt - vstart), LINE_W'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        wide_t line;
        int    vbase;
        int    snoop;
        clear_inputs();
        repeat (2) tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        // Minimum-latency read of beats 0..7.
        for (int k = 0; k < BEATS; k++) line[BUS_W*k +: BUS_W] = BUS_W'(k);
        do_read(64'h1040, line, 0, 0, -1, '0, -1, 1'b0);

        // Minimum-latency write, then a write with every ack delayed by 3 cycles.
        do_write(64'h0000_0000_0000_2000, rand_line(), 0, 0);
        for (int k = 0; k < BEATS; k++) line[BUS_W*k +: BUS_W] = BUS_W'(8'hA0 + k);
        do_write(64'h0000_0001_2345_6789, line, 3, 3);

        // Snoop between beats 3 and 4.
        do_read(64'h3000, rand_line(), 0, 0, 3, 64'h2FFF, -1, 1'b0);

        // Reset after beat 4, then a clean read.
        do_read(64'h4080, rand_line(), 1, 1, -1, '0, 4, 1'b0);
        do_read(64'h5000, rand_line(), 0, 1, -1, '0, -1, 1'b0);

        // Request pulsed while responses are being collected.
        do_read(64'h6040, rand_line(), 0, 0, -1, '0, -1, 1'b1);
        vbase = valid_cnt;
        repeat (2) begin
            tick();
            check_eq("poke_reqcyc", LINE_W'(bus_if.bus_reqcyc), '0);
        end
        check_eq("poke_valid_count", LINE_W'(valid_cnt - vbase), '0);

        // Stray read response, unknown tag and snoop while idle.
        vbase = valid_cnt;
        bus_if.bus_respcyc = 1'b1;
        bus_if.bus_resptag = TAG_READ;
        bus_if.bus_resp    = {$urandom, $urandom};
        #1;
        check_eq("stray_respack", LINE_W'(bus_if.bus_respack), LINE_W'(1));
        tick();
        bus_if.bus_resptag = 13'h1FFF;
        #1;
        check_eq("unknown_respack", LINE_W'(bus_if.bus_respack), '0);
        tick();
        check_eq("unknown_no_inv", LINE_W'(bus_if.invalidate_cache), '0);
        bus_if.bus_resptag = TAG_INVAL;
        bus_if.bus_resp    = 64'hDEAD_BEEF_0000_1234;
        #1;
        check_eq("idle_snoop_respack", LINE_W'(bus_if.bus_respack), LINE_W'(1));
        tick();
        bus_if.bus_respcyc = 1'b0;
        check_eq("idle_snoop_inv", LINE_W'(bus_if.invalidate_cache), LINE_W'(1));
        check_eq("idle_snoop_addr", LINE_W'(bus_if.invalidate_cache_addr),
                 LINE_W'(64'hDEAD_BEEF_0000_1200));
        tick();
        check_eq("stray_no_valid", LINE_W'(valid_cnt - vbase), '0);
        check_eq("stray_data_kept", bus_if.data_from_mem, model_line);

        // Randomised mix of reads and writes.
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(1, 0) == 1) begin
                do_write({$urandom, $urandom}, rand_line(), 0, 3);
            end else begin
                snoop = ($urandom_range(2, 0) == 0) ? int'($urandom_range(6, 0)) : -1;
                do_read({$urandom, $urandom}, rand_line(), int'($urandom_range(3, 0)), 2,
                        snoop, {$urandom, $urandom}, -1, 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
